// File: rtl/simd_pkg.sv
// Shared constants and types for the SIMD datapath result path.
package simd_pkg;

  localparam int PE_COUNT       = 4;
  localparam int DATA_WIDTH     = 32;
  localparam int INS_ADDR_WIDTH = 11;
  localparam int RD_LATENCY     = 2;
  localparam int FIFO_DEPTH     = 4;

  typedef logic [PE_COUNT-1:0][DATA_WIDTH-1:0] row_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VALID,
    ST_ISSUE,
    ST_DRAIN
  } drain_state_e;

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO; the head entry is presented from flops and reads as zero when empty.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_wr, do_rd;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign do_rd = rd_en && !empty;
  // A write at full is accepted only when the head leaves in the same cycle.
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_wr && !do_rd) begin
        count_q <= count_q + (PTR_W+1)'(1);
      end else if (!do_wr && do_rd) begin
        count_q <= count_q - (PTR_W+1)'(1);
      end
    end
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/result_drain.sv
// Walks BRAM R rows 0..num_rows-1 and streams them out as AXI4-Stream beats.
// Reads are credit-limited so the output FIFO can always absorb in-flight data.
module result_drain #(
  parameter int PE_COUNT       = simd_pkg::PE_COUNT,
  parameter int DATA_WIDTH     = simd_pkg::DATA_WIDTH,
  parameter int INS_ADDR_WIDTH = simd_pkg::INS_ADDR_WIDTH,
  parameter int RD_LATENCY     = simd_pkg::RD_LATENCY,
  parameter int FIFO_DEPTH     = simd_pkg::FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [INS_ADDR_WIDTH:0]        num_rows,
  input  logic                           out_data_valid,
  output logic [INS_ADDR_WIDTH-1:0]      bram_r_r_addr,
  input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_r_data,
  output logic [PE_COUNT*DATA_WIDTH-1:0] m_tdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           m_tlast,
  output logic                           busy,
  output logic                           done
);

  import simd_pkg::*;

  localparam int ROW_W = PE_COUNT * DATA_WIDTH;
  localparam int ENT_W = ROW_W + 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CTR_W = INS_ADDR_WIDTH + 1;

  drain_state_e              state_q, state_d;
  logic [CTR_W-1:0]          rows_q, issued_q;
  logic [INS_ADDR_WIDTH-1:0] addr_q;
  logic [RD_LATENCY-1:0]     pipe_vld_q, pipe_last_q;
  logic                      done_q;

  logic                      issue_en, issue_last, credit_ok, final_xfer;
  logic [CNT_W:0]            inflight;
  logic [CNT_W-1:0]          fifo_count;
  logic [ENT_W-1:0]          fifo_rd_data;
  logic                      fifo_full, fifo_empty;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + (CNT_W+1)'(pipe_vld_q[i]);
    end
  end

  // Queued rows plus outstanding reads must fit in the FIFO before a new read goes out.
  assign credit_ok  = (({1'b0, fifo_count} + inflight) < (CNT_W+1)'(FIFO_DEPTH));
  assign issue_last = (issued_q == rows_q - CTR_W'(1));
  assign final_xfer = m_tvalid && m_tready && m_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (start && num_rows != '0) state_d = ST_WAIT_VALID;
      ST_WAIT_VALID: if (out_data_valid)          state_d = ST_ISSUE;
      ST_ISSUE:      if (issue_en && issue_last)  state_d = ST_DRAIN;
      ST_DRAIN:      if (final_xfer)              state_d = ST_IDLE;
      default:                                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    issue_en      = (state_q == ST_ISSUE) && credit_ok;
    bram_r_r_addr = issue_en ? issued_q[INS_ADDR_WIDTH-1:0] : addr_q;
    busy          = (state_q != ST_IDLE);
    done          = done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q   <= '0;
      issued_q <= '0;
      addr_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == ST_IDLE && start) begin
        if (num_rows == '0) begin
          done_q <= 1'b1;
        end else begin
          rows_q   <= num_rows;
          issued_q <= '0;
        end
      end
      if (issue_en) begin
        issued_q <= issued_q + CTR_W'(1);
        addr_q   <= issued_q[INS_ADDR_WIDTH-1:0];
      end
      if (state_q == ST_DRAIN && final_xfer) begin
        done_q <= 1'b1;
      end
    end
  end

  // Read-latency tracker; the last-row tag rides along with each read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end
      pipe_vld_q[0]  <= issue_en;
      pipe_last_q[0] <= issue_en && issue_last;
    end
  end

  result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pipe_vld_q[RD_LATENCY-1]),
    .wr_data ({pipe_last_q[RD_LATENCY-1], bram_r_r_data}),
    .rd_en   (m_tready),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_tvalid          = !fifo_empty;
  assign {m_tlast, m_tdata} = fifo_rd_data;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: a BRAM model, a row-queue scoreboard and literal timing checks.
module tb_result_drain;

  localparam int PE = 4;
  localparam int DW = 32;
  localparam int AW = 11;
  localparam int RL = 2;
  localparam int RW = PE * DW;

  logic          clk = 1'b0;
  logic          rst, start, out_data_valid, m_tready;
  logic [AW:0]   num_rows;
  logic [AW-1:0] bram_r_r_addr;
  logic [RW-1:0] bram_r_r_data, m_tdata;
  logic          m_tvalid, m_tlast, busy, done;

  result_drain #(
    .PE_COUNT(PE), .DATA_WIDTH(DW), .INS_ADDR_WIDTH(AW), .RD_LATENCY(RL), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
    .out_data_valid(out_data_valid), .bram_r_r_addr(bram_r_r_addr),
    .bram_r_r_data(bram_r_r_data), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    simd_pkg::row_t data;
    logic           last;
  } beat_t;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    rmode = 0;
  int    tlast_total = 0;
  int    beat_cyc_q[$];
  beat_t exp_q[$];
  logic [RW-1:0] last_beat_data = '0;
  logic  mbusy = 1'b0;
  logic  done_pend = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [RW-1:0] row_of(input int i);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < PE; k++) r[k*DW +: DW] = DW'(i + k);
    return r;
  endfunction

  // BRAM R: address sampled at one edge, data registered RL-1 edges later.
  logic [AW-1:0] a1;
  always @(posedge clk) begin
    a1            <= bram_r_r_addr;
    bram_r_r_data <= row_of(int'(a1));
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkw(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // tready generator: always-ready, or the repeating 1,0,0,1,1,0 pattern.
  initial begin
    int pat[6];
    int pidx;
    pat = '{1, 0, 0, 1, 1, 0};
    pidx = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 1) begin
        m_tready = pat[pidx % 6][0];
        pidx++;
      end else begin
        m_tready = 1'b1;
      end
    end
  end

  // Compare process: every cycle, checks the ports against the row-queue model.
  initial begin
    beat_t         e;
    logic          fin, acc, rst_prev, stall_prev, prev_last;
    logic [RW-1:0] prev_data;
    rst_prev = 1'b0; stall_prev = 1'b0; prev_last = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      fin = 1'b0;
      if (rst_prev) begin
        chk1("rst_tvalid", m_tvalid, 1'b0);
        chk1("rst_tlast", m_tlast, 1'b0);
        chkw("rst_tdata", m_tdata, '0);
        chk1("rst_busy", busy, 1'b0);
        chki("rst_addr", int'(bram_r_r_addr), 0);
      end
      chk1("busy", busy, mbusy);
      chk1("done", done, done_pend);
      total++;
      if (int'(dut.fifo_count) > 4) begin
        bad++;
        $display("FAIL fifo_count: got %0d want <=4 (cyc %0d)", dut.fifo_count, cyc);
      end
      if (!rst) begin
        if (stall_prev) begin
          chk1("hold_valid", m_tvalid, 1'b1);
          chkw("hold_data", m_tdata, prev_data);
          chk1("hold_last", m_tlast, prev_last);
        end
        if (m_tvalid && exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_valid: got tvalid=1 want 0 (cyc %0d)", cyc);
        end else if (m_tvalid && m_tready) begin
          e = exp_q.pop_front();
          chkw("beat_data", m_tdata, e.data);
          chk1("beat_last", m_tlast, e.last);
          fin = e.last;
          beat_cyc_q.push_back(cyc);
          last_beat_data = m_tdata;
          if (m_tlast) tlast_total++;
          $display("beat %0d cyc=%0d lane0=%0d last=%0b", beat_cyc_q.size(), cyc, m_tdata[DW-1:0], m_tlast);
        end
      end
      if (rst) begin
        exp_q.delete();
        mbusy = 1'b0;
        done_pend = 1'b0;
        stall_prev = 1'b0;
      end else begin
        acc = start && !mbusy && (num_rows != '0);
        done_pend = fin || (start && !mbusy && (num_rows == '0));
        if (acc) begin
          for (int i = 0; i < int'(num_rows); i++) begin
            e.data = row_of(i);
            e.last = (i == int'(num_rows) - 1);
            exp_q.push_back(e);
          end
        end
        mbusy = mbusy ? !fin : acc;
        stall_prev = m_tvalid && !m_tready;
        prev_data = m_tdata;
        prev_last = m_tlast;
      end
      rst_prev = rst;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int maxc, input string nm, output int dcyc);
    logic seen;
    seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < maxc && !seen; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: got no done within %0d cycles, want done", nm, maxc);
    end
  endtask

  task automatic pulse_start(input int n);
    num_rows = (AW+1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int b, ovd_cyc, dcyc, t0, first;
    rst = 1'b1; start = 1'b0; num_rows = '0; out_data_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // 4 rows, start before out_data_valid.
    b = beat_cyc_q.size();
    t0 = tlast_total;
    pulse_start(4);
    repeat (4) tick();
    chk1("wait_busy", busy, 1'b1);
    chki("wait_no_beats", beat_cyc_q.size() - b, 0);
    out_data_valid = 1'b1;
    ovd_cyc = cyc;
    wait_done(50, "done4", dcyc);
    chki("n4_beats", beat_cyc_q.size() - b, 4);
    chki("n4_tlast", tlast_total - t0, 1);
    chkw("n4_final_row", last_beat_data, 128'h00000006_00000005_00000004_00000003);
    if (beat_cyc_q.size() - b == 4) begin
      first = beat_cyc_q[b];
      chki("n4_first_latency", first - ovd_cyc, RL + 2);
      chki("n4_back_to_back", beat_cyc_q[b+3] - first, 3);
      chki("n4_done_cycle", dcyc, beat_cyc_q[b+3] + 1);
    end
    repeat (3) tick();

    // 10 rows under the tready pattern; out_data_valid dropped mid-drain.
    b = beat_cyc_q.size();
    t0 = tlast_total;
    rmode = 1;
    pulse_start(10);
    repeat (3) tick();
    out_data_valid = 1'b0;
    wait_done(200, "done10", dcyc);
    rmode = 0;
    chki("n10_beats", beat_cyc_q.size() - b, 10);
    chki("n10_tlast", tlast_total - t0, 1);
    chkw("n10_final_row", last_beat_data, 128'h0000000c_0000000b_0000000a_00000009);
    chki("n10_queue_empty", exp_q.size(), 0);
    repeat (3) tick();

    // Zero rows: immediate done, never busy.
    b = beat_cyc_q.size();
    pulse_start(0);
    chk1("n0_done", done, 1'b1);
    chk1("n0_busy", busy, 1'b0);
    tick();
    chk1("n0_done_once", done, 1'b0);
    repeat (5) tick();
    chki("n0_beats", beat_cyc_q.size() - b, 0);

    // Reset in the middle of an 8-row drain, then a fresh 2-row drain.
    out_data_valid = 1'b1;
    b = beat_cyc_q.size();
    pulse_start(8);
    for (int i = 0; i < 100 && (beat_cyc_q.size() - b) < 3; i++) tick();
    chki("n8_three_beats", (beat_cyc_q.size() - b) >= 3 ? 3 : beat_cyc_q.size() - b, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("midrst_tvalid", m_tvalid, 1'b0);
    chk1("midrst_done", done, 1'b0);
    repeat (6) tick();
    b = beat_cyc_q.size();
    pulse_start(2);
    wait_done(50, "done2", dcyc);
    chki("n2_beats", beat_cyc_q.size() - b, 2);
    chkw("n2_final_row", last_beat_data, row_of(1));
    repeat (3) tick();

    // Full 2048-row drain with an ignored start in the middle.
    b = beat_cyc_q.size();
    t0 = tlast_total;
    pulse_start(2048);
    repeat (100) tick();
    pulse_start(5);
    wait_done(2300, "done2048", dcyc);
    chki("n2048_beats", beat_cyc_q.size() - b, 2048);
    chki("n2048_tlast", tlast_total - t0, 1);
    chki("n2048_last_lane0", int'(last_beat_data[DW-1:0]), 2047);
    chki("n2048_queue_empty", exp_q.size(), 0);
    repeat (10) tick();
    chk1("end_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_drain.md
Name: result_drain

Overview:
Downstream stage of datapath_top. Once the datapath asserts out_data_valid, this block walks BRAM R from row 0 to row num_rows-1 over the R read port. It streams each PE_COUNT-wide result row to the PS as an AXI4-Stream master and asserts tlast on the final row. A small credit-controlled FIFO absorbs the BRAM read latency, so backpressure never drops or duplicates a row.

Parameters:
PE_COUNT, 4, lanes per result row
DATA_WIDTH, 32, bits per lane
INS_ADDR_WIDTH, 11, BRAM R row address width
RD_LATENCY, 2, cycles from bram_r_r_addr to valid bram_r_r_data (range 1..4)
FIFO_DEPTH, 4, output FIFO entries; power of 2, must be >= RD_LATENCY+1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begin a drain
num_rows  in  INS_ADDR_WIDTH+1  row count to drain, sampled on start; 0..2^INS_ADDR_WIDTH
out_data_valid  in  1  datapath results complete and stable in BRAM R
bram_r_r_addr  out  INS_ADDR_WIDTH  BRAM R read address
bram_r_r_data  in  PE_COUNT*DATA_WIDTH  BRAM R read data, lane 0 in LSBs
m_tdata  out  PE_COUNT*DATA_WIDTH  stream data, lane 0 in LSBs
m_tvalid  out  1  stream valid
m_tready  in  1  stream ready
m_tlast  out  1  final row of the drain
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when the last row has been accepted

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state IDLE; bram_r_r_addr=0, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0.
- Reset mid-drain: FIFO, counters and the in-flight pipe are cleared. m_tvalid drops the next cycle with no tlast, and no done pulse is issued.
- FSM states: IDLE, WAIT_VALID, ISSUE, DRAIN.
- IDLE, start=1:
  - num_rows==0: pulse done next cycle, stay IDLE, busy stays 0.
  - otherwise: latch num_rows, clear counters, go to WAIT_VALID; busy=1 from the next cycle.
- start while busy: ignored.
- WAIT_VALID: stay until out_data_valid=1, then go to ISSUE. out_data_valid is needed only once; if it deasserts later the drain still completes.
- ISSUE, each cycle with credit available: drive bram_r_r_addr=issued and increment issued.
  - Credit condition: fifo_count + inflight < FIFO_DEPTH.
  - inflight = number of reads issued whose data has not yet been captured.
  - When issued reaches num_rows, go to DRAIN.
  - When no read is issued, bram_r_r_addr holds its last value.
- Read pipe: a RD_LATENCY-deep valid shift register. A read issued in cycle t is written into the FIFO at the end of cycle t+RD_LATENCY and appears on m_tdata/m_tvalid in cycle t+RD_LATENCY+1 at the earliest.
- Stream rules:
  - Transfer occurs when m_tvalid && m_tready.
  - m_tdata and m_tlast are stable while m_tvalid && !m_tready.
  - m_tlast=1 exactly on the row with index num_rows-1.
- Throughput: 1 row/cycle sustained when m_tready=1.
- Full-rate condition: FIFO_DEPTH >= RD_LATENCY+1 guarantees no bubbles at steady state.
- DRAIN: when the final tlast transfer occurs, pulse done in the next cycle, clear busy, return to IDLE.
- Counters are INS_ADDR_WIDTH+1 bits wide; num_rows = 2^INS_ADDR_WIDTH drains addresses 0..2047 with no wrap.
- Simultaneous FIFO write and read at full: permitted, count unchanged. Writes never occur when full, because credit guarantees space.

Decomposition:
- simd_pkg:
  - PE_COUNT, DATA_WIDTH and INS_ADDR_WIDTH default constants.
  - row_t: logic [PE_COUNT-1:0][DATA_WIDTH-1:0].
  - drain_state_e enum.
- Sub-module result_fifo: synchronous FIFO, parameterised width and depth; registered output; count output; full and empty flags.

Test Plan:
- Reset → all outputs 0; start with num_rows=4 while out_data_valid=0 → busy=1, no reads issued.
- Then assert out_data_valid; BRAM R row i = {i+3, i+2, i+1, i}; tready held 1 → 4 beats in consecutive cycles, first beat RD_LATENCY+1 cycles after address 0, tlast only on beat 3, done pulse the cycle after it.
- num_rows=10; m_tready toggles as the pattern 1,0,0,1,1,0 → exactly 10 beats, in order, none duplicated, data held stable during stalls, and FIFO count never exceeds 4.
- num_rows=0 → done pulse next cycle; busy stays 0; m_tvalid never asserts.
- Reset asserted after 3 of 8 rows transferred → m_tvalid low the next cycle, no done. A fresh start with num_rows=2 streams rows 0 and 1 correctly.
- num_rows=2048 with tready=1 → last beat carries address 2047 data with tlast=1; total 2048 beats; a second start pulse mid-drain is ignored.
